char_writer: RTL and testbench
==============================

# char_writer

Write side of the character (text) video memory. Accepts a byte stream over a valid/ready handshake, interprets printable ASCII and a small set of control codes, and issues one-cell-per-cycle writes into the 80x30 character memory that the VGA scan-out path reads. It maintains a text cursor, wraps lines, and performs line and full-screen clears.

## Interface
- COLS, 80, characters per row (640 px / 8 px font)
- ROWS, 30, character rows (480 px / 16 px font)
- ADDR_W, 12, character memory address width; must satisfy COLS*ROWS <= 2**ADDR_W
- FILL, 8'h20, byte written by clear operations (space)

Ports:
- clk  in  1  pixel clock, shared with the scan-out path
- clr  in  1  reset, asynchronous, active-high
- in_data  in  8  byte to interpret
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept a byte this cycle
- wr_addr  out  ADDR_W  character memory write address, row*COLS+col
- wr_data  out  8  character memory write data
- wr_en  out  1  write strobe, one write per cycle
- cur_col  out  7  cursor column, 0..COLS-1
- cur_row  out  5  cursor row, 0..ROWS-1
- busy  out  1  line or screen clear in progress

## Operation
- A byte is accepted on a rising edge with in_valid && in_ready. in_ready = (state==IDLE) && !clr.
- States:
  - IDLE: accepts a byte.
  - CLR_LINE: writes FILL to COLS cells of the cursor row, one cell per cycle, ascending column.
  - CLR_ALL: writes FILL to addresses 0..COLS*ROWS-1, ascending.
  - Both clear states return to IDLE after their last write.
- Byte decode:
  - 0x20–0x7E (printable): write the byte at the current cursor, then col+1.
    - If col was COLS-1: col=0, row=(row+1) mod ROWS, then CLR_LINE on the new row.
  - 0x0A (LF): row=(row+1) mod ROWS, col unchanged, then CLR_LINE on the new row.
  - 0x0D (CR): col=0. No write.
  - 0x08 (BS): col=col-1 if col>0, otherwise no change. No write.
  - 0x0C (FF): col=0, row=0, then CLR_ALL.
  - All other bytes (0x00–0x1F not listed above, 0x7F–0xFF): consumed, no effect.
- Row wrap: row ROWS-1 wraps to 0. There is no scrolling; the newly entered row is cleared instead.
- busy = (state != IDLE).
- cur_col and cur_row are always in range.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, cur_col=0, cur_row=0, busy=0, state IDLE. in_ready=0 while clr is high and 1 in the first cycle after release.
- wr_addr, wr_data, wr_en, cur_col, cur_row, busy are registered. Cycle N means the Nth cycle after the acceptance edge.
- Printable, no wrap:
  - wr_en=1 in cycle 1 only, with the pre-advance address.
  - Cursor shows the advanced value in cycle 1.
  - in_ready stays high, so back-to-back bytes sustain one write per cycle.
- Printable with wrap:
  - Character write in cycle 1.
  - Clear writes in cycles 2..COLS+1.
  - in_ready low in cycles 1..COLS+1, high in cycle COLS+2.
- LF:
  - Clear writes in cycles 1..COLS.
  - in_ready low in cycles 1..COLS.
- FF:
  - Clear writes in cycles 1..COLS*ROWS.
  - in_ready low for the same cycles.
- CR, BS, ignored bytes: no write, in_ready stays high, cursor updates in cycle 1.
- Reset mid-clear: clr forces wr_en low immediately (asynchronous) and abandons the clear. Partially cleared memory is left as is.
- in_data is ignored whenever in_ready=0; no byte is lost or duplicated across a busy period.

## Structure
- Shared package:
  - COLS, ROWS, ADDR_W, FILL defaults.
  - Control-code constants: CH_LF, CH_CR, CH_BS, CH_FF.
  - State enum.
- The scan-out side imports COLS/ROWS from the same package.
- Keep a row-base address register (row*COLS), updated by +COLS or reset to 0. No multiplier.
- Optional sub-module cursor_ctr: col/row counters with wrap and row-base tracking. Everything else is in one module.

## Test plan
- Reset, then send "AB" back-to-back → writes (0,'A'),(1,'B') in consecutive cycles; cur_col=2, in_ready never drops.
- Send 80 'X' from col 0, row 0 → 80 writes at 0..79. The 80th is followed by FILL writes at 80..159 over 80 cycles; cursor ends at (0,1); in_ready returns after 81 cycles.
- Cursor at row 29, send LF → FILL writes at 29*80..29*80+79 are skipped; instead FILL writes at 0..79 (row 0); cur_row=0, cur_col unchanged.
- Send 'Q', BS, BS, CR at col 5 → one write at 5; cursor ends at col 0; exactly one wr_en pulse in total.
- Send FF → 2400 writes of 0x20 at 0..2399, busy high for exactly 2400 cycles, cursor (0,0); a byte held valid during that time is accepted only afterwards.
- Assert clr at clear-write #1000 of an FF → wr_en low in the same cycle, all outputs at reset values, in_ready=1 in the first cycle after release.

Source files
------------

// File: rtl/char_writer_pkg.sv
// Shared constants and types for the character video memory (write side and scan-out).
// COLS/ROWS are the single source of truth for the 80x30 text grid.
package char_writer_pkg;

  localparam int         COLS   = 80;
  localparam int         ROWS   = 30;
  localparam int         ADDR_W = 12;
  localparam logic [7:0] FILL   = 8'h20;

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_FF = 8'h0C;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLR_LINE = 2'd1,
    CLR_ALL  = 2'd2
  } cw_state_e;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/char_writer.sv
// Byte-stream text writer: decodes printable/control bytes into one-cell-per-cycle
// character memory writes, with cursor tracking, line wrap and line/screen clears.
module char_writer
  import char_writer_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              wr_en,
  output logic [6:0]        cur_col,
  output logic [4:0]        cur_row,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam logic [6:0]        LAST_COL = 7'(COLS - 1);
  localparam logic [4:0]        LAST_ROW = 5'(ROWS - 1);
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] CELLS_M1 = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

  cw_state_e         state_q, state_d;
  logic [6:0]        col_q, col_d;
  logic [4:0]        row_q, row_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [ADDR_W-1:0] clr_left_q, clr_left_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;

  logic [4:0]        next_row;
  logic [ADDR_W-1:0] next_base;
  logic [ADDR_W-1:0] cur_addr;

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready; in_ready
  // depends only on state and clr, never on in_valid, and in_data is ignored otherwise.
  assign in_ready  = (state_q == IDLE) && !clr;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_en     = wr_en_q;
  assign cur_col   = col_q;
  assign cur_row   = row_q;

  // Row base tracks row*COLS incrementally so no multiplier is needed.
  assign next_row  = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
  assign next_base = (row_q == LAST_ROW) ? '0 : base_q + COLS_A;
  assign cur_addr  = base_q + ADDR_W'(col_q);

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    base_d     = base_q;
    clr_addr_d = clr_addr_q;
    clr_left_d = clr_left_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_printable(in_data)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cur_addr;
            wr_data_d = in_data;
            if (col_q == LAST_COL) begin
              // Wrap: the character write goes out first, the new row is cleared after it.
              col_d      = '0;
              row_d      = next_row;
              base_d     = next_base;
              clr_addr_d = next_base;
              clr_left_d = COLS_A;
              state_d    = CLR_LINE;
            end else begin
              col_d = col_q + 7'd1;
            end
          end else begin
            case (in_data)
              CH_LF: begin
                row_d      = next_row;
                base_d     = next_base;
                wr_en_d    = 1'b1;
                wr_addr_d  = next_base;
                wr_data_d  = FILL;
                clr_addr_d = next_base + ONE_A;
                clr_left_d = COLS_A - ONE_A;
                state_d    = CLR_LINE;
              end
              CH_CR: col_d = '0;
              CH_BS: if (col_q != '0) col_d = col_q - 7'd1;
              CH_FF: begin
                col_d      = '0;
                row_d      = '0;
                base_d     = '0;
                wr_en_d    = 1'b1;
                wr_addr_d  = '0;
                wr_data_d  = FILL;
                clr_addr_d = ONE_A;
                clr_left_d = CELLS_M1;
                state_d    = CLR_ALL;
              end
              default: ;
            endcase
          end
        end
      end
      CLR_LINE, CLR_ALL: begin
        if (clr_left_q == '0) begin
          state_d = IDLE;
        end else begin
          wr_en_d    = 1'b1;
          wr_addr_d  = clr_addr_q;
          wr_data_d  = FILL;
          clr_addr_d = clr_addr_q + ONE_A;
          clr_left_d = clr_left_q - ONE_A;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      base_q     <= '0;
      clr_addr_q <= '0;
      clr_left_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      base_q     <= base_d;
      clr_addr_q <= clr_addr_d;
      clr_left_q <= clr_left_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_char_writer.sv
// Bench for char_writer: table vectors, hand-written timing sequences and random bytes
// checked against a cursor/memory-write model with an expected write queue.
module tb_char_writer;
  import char_writer_pkg::*;

  localparam int W = ADDR_W + 8;

  logic              clk = 1'b0;
  logic              clr = 1'b1;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_en;
  logic [6:0]        cur_col;
  logic [4:0]        cur_row;
  logic              busy;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_pulses = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  int m_col = 0;
  int m_row = 0;

  typedef struct {
    logic [7:0] b;
    int         col;
    int         row;
    logic       wr;
    logic       bsy;
  } vec_t;
  vec_t vecs[13];

  char_writer dut (
    .clk       (clk),
    .clr       (clr),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .cur_col   (cur_col),
    .cur_row   (cur_row),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void push_wr(input int addr, input logic [7:0] d);
    exp_q.push_back({ADDR_W'(addr), d});
  endfunction

  function automatic void model_accept(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_wr(m_row * COLS + m_col, b);
      if (m_col == COLS - 1) begin
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
        for (int c = 0; c < COLS; c++) push_wr(m_row * COLS + c, 8'h20);
      end else begin
        m_col++;
      end
    end else if (b == 8'h0A) begin
      m_row = (m_row + 1) % ROWS;
      for (int c = 0; c < COLS; c++) push_wr(m_row * COLS + c, 8'h20);
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h08) begin
      if (m_col > 0) m_col--;
    end else if (b == 8'h0C) begin
      m_col = 0;
      m_row = 0;
      for (int a = 0; a < COLS * ROWS; a++) push_wr(a, 8'h20);
    end
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!clr && wr_en) begin
      wr_pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h expected no write", wr_addr, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_wr_addr", wr_addr, mon_e[W-1:8]);
        chk("sb_wr_data", wr_data, mon_e[7:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Presents a byte, waits for acceptance, returns #1 into cycle 1 after the accept edge.
  task automatic send(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 after %0d cycles expected 1", n);
    end else begin
      model_accept(b);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(posedge clk);
    #1;
    while (busy && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_idle"}, busy, 0);
    chk({name, "_drain"}, exp_q.size(), 0);
    chk({name, "_col"}, cur_col, m_col);
    chk({name, "_row"}, cur_row, m_row);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    clr = 1'b1;
    repeat (3) @(posedge clk);
    exp_q.delete();
    m_col = 0;
    m_row = 0;
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    int c0;
    int p0;
    logic [7:0] b;

    vecs[0]  = '{8'h48, 1, 0, 1'b1, 1'b0};
    vecs[1]  = '{8'h69, 2, 0, 1'b1, 1'b0};
    vecs[2]  = '{8'h08, 1, 0, 1'b0, 1'b0};
    vecs[3]  = '{8'h0D, 0, 0, 1'b0, 1'b0};
    vecs[4]  = '{8'h08, 0, 0, 1'b0, 1'b0};
    vecs[5]  = '{8'h00, 0, 0, 1'b0, 1'b0};
    vecs[6]  = '{8'h7F, 0, 0, 1'b0, 1'b0};
    vecs[7]  = '{8'hFF, 0, 0, 1'b0, 1'b0};
    vecs[8]  = '{8'h7E, 1, 0, 1'b1, 1'b0};
    vecs[9]  = '{8'h20, 2, 0, 1'b1, 1'b0};
    vecs[10] = '{8'h1F, 2, 0, 1'b0, 1'b0};
    vecs[11] = '{8'h0A, 2, 1, 1'b1, 1'b1};
    vecs[12] = '{8'h7A, 3, 1, 1'b1, 1'b0};

    // Reset values while clr is held
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_col", cur_col, 0);
    chk("rst_row", cur_row, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", dbg_state, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("rst_release_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Table vectors: cursor/wr_en/busy in cycle 1 after each byte
    for (int i = 0; i < 13; i++) begin
      send(vecs[i].b);
      chk($sformatf("vec%0d_col", i), cur_col, vecs[i].col);
      chk($sformatf("vec%0d_row", i), cur_row, vecs[i].row);
      chk($sformatf("vec%0d_wr_en", i), wr_en, vecs[i].wr);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].bsy);
    end
    wait_idle("vec");

    // "AB" back-to-back
    do_reset();
    send(8'h41);
    c0 = cyc;
    chk("ab_a_wr_en", wr_en, 1);
    chk("ab_a_addr", wr_addr, 0);
    chk("ab_a_ready", in_ready, 1);
    send(8'h42);
    chk("ab_consecutive", cyc - c0, 1);
    chk("ab_b_wr_en", wr_en, 1);
    chk("ab_b_addr", wr_addr, 1);
    chk("ab_b_ready", in_ready, 1);
    chk("ab_col", cur_col, 2);
    wait_idle("ab");

    // 80 'X' from (0,0): wrap then clear of row 1
    do_reset();
    for (int i = 0; i < COLS; i++) send(8'h58);
    chk("wrap_col", cur_col, 0);
    chk("wrap_row", cur_row, 1);
    chk("wrap_last_addr", wr_addr, COLS - 1);
    n = 1;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("wrap_ready_cycle", n, COLS + 2);
    wait_idle("wrap");

    // LF at the last row wraps to row 0 and clears it
    for (int i = 0; i < ROWS - 2; i++) send(8'h0A);
    wait_idle("lf_prep");
    chk("lf_prep_row", cur_row, ROWS - 1);
    send(8'h61);
    send(8'h62);
    send(8'h0A);
    chk("lf29_row", cur_row, 0);
    chk("lf29_col", cur_col, 2);
    chk("lf29_first_addr", wr_addr, 0);
    n = 1;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("lf29_ready_cycle", n, COLS + 1);
    wait_idle("lf29");

    // 'Q', BS, BS, CR at col 5
    send(8'h78);
    send(8'h79);
    send(8'h7A);
    wait_idle("q_prep");
    chk("q_prep_col", cur_col, 5);
    p0 = wr_pulses;
    send(8'h51);
    chk("q_addr", wr_addr, 5);
    send(8'h08);
    send(8'h08);
    send(8'h0D);
    wait_idle("q");
    chk("q_pulses", wr_pulses - p0, 1);
    chk("q_col", cur_col, 0);

    // FF with a byte held valid through the clear
    send(8'h0C);
    in_data = 8'h4B;
    in_valid = 1'b1;
    n = 0;
    while (busy && n < 3000) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("ff_busy_cycles", n, COLS * ROWS);
    chk("ff_col", cur_col, 0);
    chk("ff_row", cur_row, 0);
    chk("ff_ready_after", in_ready, 1);
    model_accept(8'h4B);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("ff_held_wr_en", wr_en, 1);
    chk("ff_held_addr", wr_addr, 0);
    chk("ff_held_data", wr_data, 8'h4B);
    wait_idle("ff");

    // Reset asserted at clear write #1000 of an FF
    send(8'h0C);
    repeat (999) begin
      @(posedge clk);
      #1;
    end
    chk("mid_pre_wr_en", wr_en, 1);
    chk("mid_pre_addr", wr_addr, 999);
    clr = 1'b1;
    #1;
    chk("mid_wr_en", wr_en, 0);
    chk("mid_wr_addr", wr_addr, 0);
    chk("mid_wr_data", wr_data, 0);
    chk("mid_col", cur_col, 0);
    chk("mid_row", cur_row, 0);
    chk("mid_busy", busy, 0);
    chk("mid_ready", in_ready, 0);
    exp_q.delete();
    m_col = 0;
    m_row = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("mid_release_ready", in_ready, 1);
    @(posedge clk);
    #1;
    chk("mid_release_busy", busy, 0);
    chk("mid_release_wr_en", wr_en, 0);

    // Random byte stream against the model
    for (int i = 0; i < 400; i++) begin
      n = $urandom_range(0, 99);
      if (n < 70)      b = 8'($urandom_range(32, 126));
      else if (n < 76) b = 8'h0A;
      else if (n < 84) b = 8'h0D;
      else if (n < 92) b = 8'h08;
      else if (n < 93) b = 8'h0C;
      else             b = 8'($urandom_range(0, 255));
      send(b);
      chk("rnd_col", cur_col, m_col);
      chk("rnd_row", cur_row, m_row);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    wait_idle("rnd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
